// File: rtl/seq_mult_unit_pkg.sv
// Shared constants for the sequential multiplier: widths, iteration count and FSM states.
package seq_mult_unit_pkg;
  localparam int DATA_W    = 32;
  localparam int MUL_ITERS = 32;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/seq_mult_unit_adder.sv
// 32-bit carry-select adder: four 8-bit blocks, each precomputing sums for carry-in 0 and 1.
module hybrid_adder
  import seq_mult_unit_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);
  localparam int BLK  = 8;
  localparam int NBLK = DATA_W / BLK;
  localparam logic [BLK:0] ONE = 1;

  logic [NBLK:0] carry;

  assign carry[0] = cin;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK:0] s0;
    logic [BLK:0] s1;
    assign s0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
    assign s1 = s0 + ONE;
    assign sum[g*BLK +: BLK] = carry[g] ? s1[BLK-1:0] : s0[BLK-1:0];
    assign carry[g+1]        = carry[g] ? s1[BLK]     : s0[BLK];
  end

  assign cout = carry[NBLK];
endmodule

// File: rtl/seq_mult_unit.sv
// Sequential 32x32 shift-add multiplier, signed or unsigned, fixed 34-cycle latency.
module seq_mult_unit
  import seq_mult_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] prod_hi,
  output logic [DATA_W-1:0] prod_lo
);
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              neg;
  logic [DATA_W-1:0] addend;
  logic [DATA_W-1:0] sum;
  logic              cout;

  // 0x80000000 negates to itself, which read unsigned is exactly 2^31.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] negate64(input logic [2*DATA_W-1:0] p);
    return -p;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= CALC;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(MUL_ITERS - 1)) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign addend = mplier[0] ? mcand : '0;

  hybrid_adder u_adder (
    .a    (hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // The adder carry enters the top of hi as {cout,sum,lo} shifts right by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= magnitude(op_a, signed_mode);
          mplier <= magnitude(op_b, signed_mode);
          neg    <= signed_mode & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
          hi     <= '0;
          lo     <= '0;
        end
        CALC: begin
          hi     <= {cout, sum[DATA_W-1:1]};
          lo     <= {sum[0], lo[DATA_W-1:1]};
          mplier <= mplier >> 1;
        end
        FIX: if (neg) {hi, lo} <= negate64({hi, lo});
        default: ;
      endcase
    end
  end

  assign prod_hi = hi;
  assign prod_lo = lo;
endmodule

// File: tb/tb_seq_mult_unit.sv
// Scoreboard bench for seq_mult_unit: stimulus queues expected products, a monitor checks on done.
module tb_seq_mult_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] prod;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mult_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .prod_hi     (prod_hi),
    .prod_lo     (prod_lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d want no pending op", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_prod"}, {prod_hi, prod_lo}, e.prod);
        check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue(input string name, input logic sm, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] expv);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    signed_mode = sm;
    op_a = a;
    op_b = b;
    e.prod = expv;
    e.cyc  = cyc + 34;
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: pending=%0d want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input string name, input logic sm, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] expv);
    issue(name, sm, a, b, expv);
    wait_drain(name);
    repeat (2) @(negedge clk);
    check({name, "_hold"}, {prod_hi, prod_lo}, expv);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_prod", {prod_hi, prod_lo}, 64'd0);
    rst = 1'b0;

    issue("u4x8", 1'b0, 32'd4, 32'd8, 64'h0000_0000_0000_0020);
    for (int k = 1; k <= 35; k++) begin
      check($sformatf("busy_c%0d", k), 64'(busy), (k <= 33) ? 64'd1 : 64'd0);
      @(negedge clk);
    end
    wait_drain("u4x8");

    run_op("s_m3x7",    1'b1, 32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB);
    run_op("u_max2",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("s_m1m1",    1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_op("s_min2",    1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("s_zero",    1'b1, 32'd0,         32'hFFFF_FFFB, 64'h0000_0000_0000_0000);
    run_op("s_m2m3",    1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'h0000_0000_0000_0006);
    run_op("u_2p31x2",  1'b0, 32'h8000_0000, 32'd2,        64'h0000_0001_0000_0000);

    // Abort mid-CALC: outputs clear at once and the aborted op never completes.
    issue("abort", 1'b0, 32'd1000, 32'd1000, 64'd1000000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_prod", {prod_hi, prod_lo}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_idle_busy", 64'(busy), 64'd0);
    check("abort_idle_prod", {prod_hi, prod_lo}, 64'd0);
    run_op("u5x6", 1'b0, 32'd5, 32'd6, 64'h0000_0000_0000_001E);

    // Start during CALC and during DONE must both be ignored.
    issue("ignore", 1'b0, 32'd3, 32'd9, 64'd27);
    repeat (5) @(negedge clk);
    start = 1'b1;
    signed_mode = 1'b1;
    op_a = 32'd100;
    op_b = 32'hFFFF_FF9C;
    @(negedge clk);
    start = 1'b0;
    wait_drain("ignore");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("ignore_done_busy", 64'(busy), 64'd0);
    check("ignore_hold", {prod_hi, prod_lo}, 64'd27);

    repeat (40) @(negedge clk);
    check("final_pending", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
